// File: rtl/synchro_wavegen_counter_if.sv
// synchro_wavegen_counter_if: control, limit and waveform output signals of the wavegen counter
interface synchro_wavegen_counter_if #(
  parameter int WIDTH = 12,
  parameter int STEP_WIDTH = 3,
  parameter int DELTA_WIDTH = 4
);
  logic clk_in;
  logic set;
  logic [WIDTH-1:0] preset_value;
  logic set_dir;
  logic [1:0] mode;
  logic [WIDTH-1:0] limit_up;
  logic [WIDTH-1:0] limit_down;
  logic [STEP_WIDTH-1:0] step;
  logic [DELTA_WIDTH-1:0] delta;
  logic [WIDTH-1:0] out;
  logic dir;
  logic carry;
  modport master (
    output clk_in, set, preset_value, set_dir, mode, limit_up, limit_down, step, delta,
    input out, dir, carry
  );
  modport slave (
    input clk_in, set, preset_value, set_dir, mode, limit_up, limit_down, step, delta,
    output out, dir, carry
  );
endinterface

// File: rtl/synchro_wavegen_counter.sv
// synchro_wavegen_counter: prescaled, clamped up/down waveform counter (triangle, saw-up, saw-down, hold)
module synchro_wavegen_counter #(
  parameter int WIDTH = 12,
  parameter int STEP_WIDTH = 3,
  parameter int DELTA_WIDTH = 4
) (
  input logic qzt_clk,
  input logic reset,
  synchro_wavegen_counter_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  typedef enum logic [1:0] {TRI = 2'b00, SAW_UP = 2'b01, SAW_DN = 2'b10, HOLD = 2'b11} mode_t;
  mode_t md;
  logic [WIDTH-1:0] cnt_q, nxt_out, up_lim, dn_lim;
  logic [STEP_WIDTH-1:0] pre_q;
  logic clk_in_old, dir_q, carry_q, nxt_dir, nxt_carry;
  logic [WIDTH:0] up_sum, dn_diff;
  logic tick, run, adv, degen, delta_nz;
  assign bus.out = cnt_q;
  assign bus.dir = dir_q;
  assign bus.carry = carry_q;
  // Sums are formed one bit wider so overflow/underflow clamp to a limit instead of wrapping.
  always_comb begin
    md = mode_t'(bus.mode);
    tick = bus.clk_in & ~clk_in_old;
    run = tick & (md != HOLD);
    adv = run & (pre_q == bus.step);
    delta_nz = |bus.delta;
    degen = bus.limit_down >= bus.limit_up;
    up_sum = {1'b0, cnt_q} + W1'(bus.delta);
    dn_diff = {1'b0, cnt_q} - W1'(bus.delta);
    up_lim = (up_sum >= {1'b0, bus.limit_up}) ? bus.limit_up : up_sum[WIDTH-1:0];
    dn_lim = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] <= bus.limit_down)) ? bus.limit_down : dn_diff[WIDTH-1:0];
    nxt_out = cnt_q;
    nxt_dir = dir_q;
    nxt_carry = 1'b0;
    if (degen)
      nxt_out = bus.limit_down;
    else if (cnt_q > bus.limit_up)
      nxt_out = bus.limit_up;
    else if (cnt_q < bus.limit_down)
      nxt_out = bus.limit_down;
    else if (md == TRI) begin
      nxt_out = dir_q ? up_lim : dn_lim;
      nxt_carry = nxt_out == (dir_q ? bus.limit_up : bus.limit_down);
      nxt_dir = nxt_carry ? ~dir_q : dir_q;
    end else if (md == SAW_UP) begin
      nxt_dir = 1'b1;
      nxt_carry = (cnt_q == bus.limit_up) && delta_nz;
      nxt_out = nxt_carry ? bus.limit_down : up_lim;
    end else begin
      nxt_dir = 1'b0;
      nxt_carry = (cnt_q == bus.limit_down) && delta_nz;
      nxt_out = nxt_carry ? bus.limit_up : dn_lim;
    end
  end
  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      dir_q <= 1'b1;
      carry_q <= 1'b0;
      pre_q <= '0;
      clk_in_old <= 1'b0;
    end else begin
      clk_in_old <= bus.clk_in;
      carry_q <= 1'b0;
      if (bus.set) begin
        cnt_q <= bus.preset_value;
        dir_q <= bus.set_dir;
        pre_q <= '0;
      end else if (run) begin
        pre_q <= adv ? '0 : pre_q + 1'b1;
        if (adv) begin
          cnt_q <= nxt_out;
          dir_q <= nxt_dir;
          carry_q <= nxt_carry;
        end
      end
    end
  end
endmodule

// File: tb/tb_synchro_wavegen_counter.sv
// tb_synchro_wavegen_counter: scoreboard bench, expected out/dir/carry queued per tick and checked after the edge
module tb_synchro_wavegen_counter;
  typedef struct {
    logic [11:0] out;
    logic dir;
    logic carry;
  } exp_t;
  logic qzt_clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  synchro_wavegen_counter_if #(.WIDTH(12), .STEP_WIDTH(3), .DELTA_WIDTH(4)) b ();
  synchro_wavegen_counter #(.WIDTH(12), .STEP_WIDTH(3), .DELTA_WIDTH(4)) dut (
    .qzt_clk(qzt_clk),
    .reset(reset),
    .bus(b)
  );
  always #5 qzt_clk = ~qzt_clk;

  task automatic tick();
    @(negedge qzt_clk) b.clk_in = 1'b1;
    @(negedge qzt_clk);
  endtask

  task automatic cfg(input logic [1:0] m, input logic [11:0] lu, input logic [11:0] ld,
                     input logic [2:0] s, input logic [3:0] d);
    b.mode = m;
    b.limit_up = lu;
    b.limit_down = ld;
    b.step = s;
    b.delta = d;
  endtask

  task automatic load(input logic [11:0] v, input logic d);
    @(negedge qzt_clk);
    b.preset_value = v;
    b.set_dir = d;
    b.set = 1'b1;
    @(negedge qzt_clk);
    b.set = 1'b0;
  endtask

  task automatic push(input logic [11:0] o, input logic d, input logic c);
    sb.push_back('{o, d, c});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge qzt_clk);
    b.clk_in = 1'b1;
    @(negedge qzt_clk);
    checks++;
    if (b.out !== 12'd0 || b.dir !== 1'b1 || b.carry !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%0d dir=%b carry=%b, expected out=0 dir=1 carry=0", b.out, b.dir, b.carry);
    end
    b.clk_in = 1'b0;
    @(negedge qzt_clk);
    reset = 1'b1;
    @(negedge qzt_clk);
  endtask

  task automatic test_triangle_small();
    cfg(2'b00, 12'd6, 12'd2, 3'd0, 4'd1);
    push(2, 1, 0); push(3, 1, 0); push(4, 1, 0); push(5, 1, 0); push(6, 0, 1);
    push(5, 0, 0); push(4, 0, 0); push(3, 0, 0); push(2, 1, 1); push(3, 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL tri_small: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
      checks++;
      if (b.carry !== 1'b0) begin
        errors++;
        $display("FAIL tri_small_carry_width: carry=%b, expected 0", b.carry);
      end
    end
  endtask

  task automatic test_triangle_delta4();
    cfg(2'b00, 12'd10, 12'd0, 3'd0, 4'd4);
    load(12'd0, 1'b1);
    push(4, 1, 0); push(8, 1, 0); push(10, 0, 1); push(6, 0, 0);
    push(2, 0, 0); push(0, 1, 1); push(4, 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL tri_delta4: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
      checks++;
      if (b.carry !== 1'b0) begin
        errors++;
        $display("FAIL tri_delta4_carry_width: carry=%b, expected 0", b.carry);
      end
    end
  endtask

  task automatic test_saw_up_prescale();
    cfg(2'b01, 12'd8, 12'd5, 3'd2, 4'd1);
    load(12'd5, 1'b1);
    push(5, 1, 0); push(5, 1, 0); push(6, 1, 0);
    push(6, 1, 0); push(6, 1, 0); push(7, 1, 0);
    push(7, 1, 0); push(7, 1, 0); push(8, 1, 0);
    push(8, 1, 0); push(8, 1, 0); push(5, 1, 1);
    push(5, 1, 0); push(5, 1, 0); push(6, 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL saw_up: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
    end
  endtask

  task automatic test_saw_down_clamp();
    cfg(2'b10, 12'd4095, 12'd0, 3'd0, 4'd15);
    load(12'd10, 1'b1);
    push(0, 0, 0); push(4095, 0, 1); push(4080, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL saw_down: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
    end
  endtask

  task automatic test_hold();
    cfg(2'b00, 12'd20, 12'd0, 3'd1, 4'd1);
    load(12'd9, 1'b0);
    push(9, 0, 0); push(8, 0, 0); push(8, 0, 0); push(7, 0, 0); push(7, 0, 0);
    for (int i = 0; i < 20; i++) push(7, 0, 0);
    for (int i = 0; i < 25; i++) begin
      if (i == 5) b.mode = 2'b11;
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL hold: tick %0d out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", i, b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
    end
    b.mode = 2'b00;
    push(6, 0, 0); push(6, 0, 0); push(5, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL hold_resume: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
    end
  endtask

  task automatic test_reset_set_priority();
    cfg(2'b00, 12'd100, 12'd0, 3'd0, 4'd1);
    load(12'd9, 1'b1);
    @(negedge qzt_clk);
    b.clk_in = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b.out !== 12'd0 || b.dir !== 1'b1 || b.carry !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%0d dir=%b carry=%b, expected out=0 dir=1 carry=0", b.out, b.dir, b.carry);
    end
    @(negedge qzt_clk);
    checks++;
    if (b.out !== 12'd0) begin
      errors++;
      $display("FAIL reset_held: out=%0d, expected 0", b.out);
    end
    b.preset_value = 12'd33;
    b.set_dir = 1'b0;
    b.set = 1'b1;
    reset = 1'b1;
    @(negedge qzt_clk);
    checks++;
    if (b.out !== 12'd33 || b.dir !== 1'b0 || b.carry !== 1'b0) begin
      errors++;
      $display("FAIL set_over_tick: out=%0d dir=%b carry=%b, expected out=33 dir=0 carry=0", b.out, b.dir, b.carry);
    end
    b.set = 1'b0;
    b.clk_in = 1'b0;
    @(negedge qzt_clk);
    push(32, 0, 0); push(31, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick();
      checks++;
      if (b.out !== e.out || b.dir !== e.dir || b.carry !== e.carry) begin
        errors++;
        $display("FAIL after_set: out=%0d dir=%b carry=%b, expected out=%0d dir=%b carry=%b", b.out, b.dir, b.carry, e.out, e.dir, e.carry);
      end
      b.clk_in = 1'b0;
      @(negedge qzt_clk);
    end
  endtask

  initial begin
    b.clk_in = 1'b0;
    b.set = 1'b0;
    b.preset_value = '0;
    b.set_dir = 1'b1;
    cfg(2'b00, 12'd6, 12'd2, 3'd0, 4'd1);
    test_reset();
    test_triangle_small();
    test_triangle_delta4();
    test_saw_up_prescale();
    test_saw_down_clamp();
    test_hold();
    test_reset_set_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
